// File: rtl/mips_ext_pkg.sv
// Shared definitions for the immediate-extension pipeline.
//   ext_mode_e   : encoding of the in_mode port (ZEXT, SEXT, UPPER, BROFF)
//   fifo_state_e : occupancy state of the 2-entry output buffer
//   DEF_IN_W / DEF_OUT_W : default immediate and result widths
package mips_ext_pkg;

   localparam int unsigned DEF_IN_W  = 16;
   localparam int unsigned DEF_OUT_W = 32;

   typedef enum logic [1:0] {
      ZEXT  = 2'd0,
      SEXT  = 2'd1,
      UPPER = 2'd2,
      BROFF = 2'd3
   } ext_mode_e;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } fifo_state_e;

endpackage

// File: rtl/ext_skid_buffer.sv
// Two-entry FIFO skid buffer holding extended results.
// Ports:
//   clk, rst_n  : rising-edge clock, asynchronous active-low reset
//   push        : write push_data (caller guarantees push only while in_ready)
//   push_data   : OUT_W-bit entry to store
//   pop         : consumer ready; an entry leaves when pop && out_valid
//   in_ready    : registered, high in EMPTY/ONE, low in FULL
//   out_valid   : registered, high in ONE/FULL
//   out_data    : oldest entry (head register)
module ext_skid_buffer
   import mips_ext_pkg::*;
#(
   parameter int unsigned OUT_W = DEF_OUT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [OUT_W-1:0] push_data,
   input  logic             pop,
   output logic             in_ready,
   output logic             out_valid,
   output logic [OUT_W-1:0] out_data
);

   fifo_state_e      state;
   logic [OUT_W-1:0] tail;

   // Head register drives out_data directly so it only moves on a pop
   // (or on the first push into an empty buffer).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= EMPTY;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         tail      <= '0;
      end else begin
         case (state)
            EMPTY: begin
               // Also raises in_ready on the first edge after reset release.
               in_ready <= 1'b1;
               if (push) begin
                  out_data  <= push_data;
                  out_valid <= 1'b1;
                  state     <= ONE;
               end
            end
            ONE: begin
               case ({push, pop})
                  2'b10: begin
                     tail     <= push_data;
                     in_ready <= 1'b0;
                     state    <= FULL;
                  end
                  2'b01: begin
                     out_valid <= 1'b0;
                     state     <= EMPTY;
                  end
                  2'b11: out_data <= push_data;
                  default: ;
               endcase
            end
            FULL: begin
               if (pop) begin
                  out_data <= tail;
                  in_ready <= 1'b1;
                  state    <= ONE;
               end
            end
            default: begin
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               state     <= EMPTY;
            end
         endcase
      end
   end

endmodule

// File: rtl/imm_extend_pipe.sv
// Immediate extension pipeline: extends in_imm according to in_mode and
// delivers the result through a 2-entry skid buffer with 1-cycle latency.
// Ports:
//   clk, rst_n           : rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready  : input handshake (in_ready is registered)
//   in_imm, in_mode      : raw immediate and mode (ZEXT/SEXT/UPPER/BROFF)
//   out_valid / out_ready: output handshake
//   out_data             : extended result, oldest first
//   xfer_count           : 16-bit wrapping output transfer count, present
//                          only when IMM_EXT_COUNT_EN is defined
// Configuration macro: IMM_EXT_COUNT_EN
module imm_extend_pipe
   import mips_ext_pkg::*;
#(
   parameter int unsigned IN_W  = DEF_IN_W,
   parameter int unsigned OUT_W = DEF_OUT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_imm,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data
`ifdef IMM_EXT_COUNT_EN
   ,
   output logic [15:0]      xfer_count
`endif
);

   generate
      if (OUT_W < IN_W + 2) begin : g_width_check
         $error("imm_extend_pipe: OUT_W must be at least IN_W+2");
      end
   endgenerate

   logic [OUT_W-1:0] sext_val;
   logic [OUT_W-1:0] ext_val;
   logic             push;

   assign sext_val = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};
   assign push     = in_valid && in_ready;

   always_comb begin
      ext_val = '0;
      case (ext_mode_e'(in_mode))
         ZEXT:    ext_val = {{(OUT_W-IN_W){1'b0}}, in_imm};
         SEXT:    ext_val = sext_val;
         UPPER:   ext_val = {in_imm, {(OUT_W-IN_W){1'b0}}};
         BROFF:   ext_val = {sext_val[OUT_W-3:0], 2'b00};
         default: ext_val = '0;
      endcase
   end

   ext_skid_buffer #(
      .OUT_W (OUT_W)
   ) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (ext_val),
      .pop       (out_ready),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data)
   );

`ifdef IMM_EXT_COUNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xfer_count <= '0;
      end else if (out_valid && out_ready) begin
         xfer_count <= xfer_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
module tb_imm_extend_pipe;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_imm;
   logic [1:0]  in_mode;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;

   int unsigned pass_cnt;
   int unsigned total_cnt;

   imm_extend_pipe #(
      .IN_W  (16),
      .OUT_W (32)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_imm    (in_imm),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Advance past the next rising edge; outputs are then stable for checking.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_imm    = '0;
      in_mode   = 2'd0;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_imm    = '0;
      in_mode   = 2'd0;
      #3;
      total_cnt++;
      if ({in_ready, out_valid, out_data} !== {1'b0, 1'b0, 32'h0})
         $display("FAIL reset_state: got rdy=%b vld=%b data=%h, want 0 0 00000000",
                  in_ready, out_valid, out_data);
      else pass_cnt++;
      step();
      step();
      rst_n = 1'b1;
      #1;
      total_cnt++;
      if (in_ready !== 1'b0)
         $display("FAIL ready_before_edge: got %b want 0", in_ready);
      else pass_cnt++;
      step();
      total_cnt++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0)
         $display("FAIL ready_after_release: got rdy=%b vld=%b want 1 0", in_ready, out_valid);
      else pass_cnt++;
   endtask

   task automatic test_modes();
      logic [31:0] exp_tab [4];
      exp_tab[0] = 32'h0000_8001;
      exp_tab[1] = 32'hFFFF_8001;
      exp_tab[2] = 32'h8001_0000;
      exp_tab[3] = 32'hFFFE_0004;
      apply_reset();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_imm    = 16'h8001;
      for (int m = 0; m < 4; m++) begin
         in_mode = 2'(m);
         step();
         total_cnt++;
         if (out_valid !== 1'b1 || out_data !== exp_tab[m] || in_ready !== 1'b1)
            $display("FAIL mode_%0d: got vld=%b data=%h rdy=%b, want 1 %h 1",
                     m, out_valid, out_data, in_ready, exp_tab[m]);
         else pass_cnt++;
      end
      in_valid = 1'b0;
      step();
      total_cnt++;
      if (out_valid !== 1'b0)
         $display("FAIL modes_drain: got vld=%b want 0", out_valid);
      else pass_cnt++;
   endtask

   task automatic test_backpressure();
      apply_reset();
      out_ready = 1'b0;
      in_mode   = 2'd1;
      in_valid  = 1'b1;
      in_imm    = 16'h0001;
      step();
      total_cnt++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_data !== 32'h1)
         $display("FAIL bp_beat1: got vld=%b rdy=%b data=%h want 1 1 00000001",
                  out_valid, in_ready, out_data);
      else pass_cnt++;
      in_imm = 16'h0002;
      step();
      total_cnt++;
      if (in_ready !== 1'b0 || out_data !== 32'h1)
         $display("FAIL bp_full: got rdy=%b data=%h want 0 00000001", in_ready, out_data);
      else pass_cnt++;
      in_imm = 16'h0003;
      step();
      total_cnt++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h1)
         $display("FAIL bp_holdoff: got rdy=%b vld=%b data=%h want 0 1 00000001",
                  in_ready, out_valid, out_data);
      else pass_cnt++;
      out_ready = 1'b1;
      step();
      total_cnt++;
      if (out_data !== 32'h2 || in_ready !== 1'b1)
         $display("FAIL bp_drain2: got data=%h rdy=%b want 00000002 1", out_data, in_ready);
      else pass_cnt++;
      step();
      total_cnt++;
      if (out_data !== 32'h3 || out_valid !== 1'b1)
         $display("FAIL bp_drain3: got data=%h vld=%b want 00000003 1", out_data, out_valid);
      else pass_cnt++;
      in_valid = 1'b0;
      step();
      total_cnt++;
      if (out_valid !== 1'b0)
         $display("FAIL bp_empty: got vld=%b want 0", out_valid);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      apply_reset();
      out_ready = 1'b1;
      in_mode   = 2'd0;
      in_valid  = 1'b1;
      for (int c = 1; c <= 100; c++) begin
         in_imm = 16'(c);
         step();
         total_cnt++;
         if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_data !== 32'(c))
            $display("FAIL stream_beat_%0d: got vld=%b rdy=%b data=%h want 1 1 %h",
                     c, out_valid, in_ready, out_data, 32'(c));
         else pass_cnt++;
      end
      in_valid = 1'b0;
      step();
      total_cnt++;
      if (out_valid !== 1'b0)
         $display("FAIL stream_done_101: got vld=%b want 0", out_valid);
      else pass_cnt++;
   endtask

   task automatic test_async_reset();
      apply_reset();
      out_ready = 1'b0;
      in_mode   = 2'd0;
      in_valid  = 1'b1;
      in_imm    = 16'h00AA;
      step();
      in_imm = 16'h00BB;
      step();
      in_valid = 1'b0;
      total_cnt++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1)
         $display("FAIL ar_full: got rdy=%b vld=%b want 0 1", in_ready, out_valid);
      else pass_cnt++;
      #2;
      rst_n = 1'b0;
      #1;
      total_cnt++;
      if ({in_ready, out_valid, out_data} !== {1'b0, 1'b0, 32'h0})
         $display("FAIL ar_async_drop: got rdy=%b vld=%b data=%h want 0 0 00000000",
                  in_ready, out_valid, out_data);
      else pass_cnt++;
      step();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      step();
      step();
      step();
      total_cnt++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL ar_no_stale: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
      else pass_cnt++;
      in_valid = 1'b1;
      in_imm   = 16'h1234;
      step();
      in_valid = 1'b0;
      total_cnt++;
      if (out_valid !== 1'b1 || out_data !== 32'h0000_1234)
         $display("FAIL ar_new_beat: got vld=%b data=%h want 1 00001234", out_valid, out_data);
      else pass_cnt++;
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      test_reset();
      test_modes();
      test_backpressure();
      test_back_to_back();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
